// File: rtl/ap1000_dcm_lock_supervisor.sv
// DCM reset/lock supervisor: pulses the DCM reset, waits for LOCKED, confirms
// it is stable, retries on timeout and re-acquires on loss of lock. Clocked by
// the DCM reference clock so it never depends on the clock being supervised.
module ap1000_dcm_lock_supervisor #(
  parameter logic [3:0]  RST_PULSE_CYCLES    = 4'd8,
  parameter logic [15:0] LOCK_TIMEOUT_CYCLES = 16'd50000,
  parameter logic [3:0]  STABLE_CYCLES       = 4'd8,
  parameter logic [3:0]  MAX_RETRIES         = 4'd15,
  parameter int unsigned TIMER_W             = 16
) (
  input  logic       ref_clk,
  input  logic       async_fpga_rst_n,
  input  logic       dcm_locked,
  input  logic       soft_rst_req,
  output logic       dcm_rst,
  output logic       lock_ok,
  output logic       lock_lost_pulse,
  output logic       lock_fail,
  output logic [3:0] retry_count
);

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RST_PULSE_CYCLES) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES) - TIMER_W'(1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES) - TIMER_W'(1);

  typedef enum logic [2:0] {
    ST_RST_PULSE,
    ST_WAIT_LOCK,
    ST_STABLE_CHECK,
    ST_LOCKED,
    ST_FAILED
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic               locked_meta_q, locked_s_q;
  logic               dcm_rst_q, dcm_rst_d;
  logic               lock_ok_q, lock_ok_d;
  logic               lost_q, lost_d;
  logic               fail_q, fail_d;

  // Two-flop synchroniser for the asynchronous DCM LOCKED signal.
  always_ff @(posedge ref_clk or negedge async_fpga_rst_n) begin
    if (!async_fpga_rst_n) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= dcm_locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  // State, shared phase counter, retry counter and registered outputs.
  always_ff @(posedge ref_clk or negedge async_fpga_rst_n) begin
    if (!async_fpga_rst_n) begin
      state_q   <= ST_RST_PULSE;
      cnt_q     <= '0;
      retry_q   <= '0;
      dcm_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      lost_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dcm_rst_q <= dcm_rst_d;
      lock_ok_q <= lock_ok_d;
      lost_q    <= lost_d;
      fail_q    <= fail_d;
    end
  end

  // Next-state logic; one counter serves pulse length, lock timeout and
  // stability count, and is cleared on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_RST_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABLE_CHECK;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q >= MAX_RETRIES) begin
            state_d = ST_FAILED;
          end else begin
            state_d = ST_RST_PULSE;
            retry_d = retry_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end
      ST_STABLE_CHECK: begin
        if (!locked_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TIMER_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!locked_s_q) begin
          state_d = ST_RST_PULSE;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_FAILED: begin
        state_d = ST_FAILED;
      end
      default: begin
        state_d = ST_RST_PULSE;
        cnt_d   = '0;
      end
    endcase

    // Soft request overrides everything above, including a same-cycle
    // timeout, so it never charges a retry.
    if (soft_rst_req) begin
      state_d = ST_RST_PULSE;
      cnt_d   = '0;
      retry_d = (state_q == ST_LOCKED || state_q == ST_FAILED) ? '0 : retry_q;
    end

    dcm_rst_d = (state_d == ST_RST_PULSE);
    lock_ok_d = (state_d == ST_LOCKED);
    fail_d    = (state_d == ST_FAILED);
    lost_d    = (state_q == ST_LOCKED) && !locked_s_q;
  end

  assign dcm_rst         = dcm_rst_q;
  assign lock_ok         = lock_ok_q;
  assign lock_lost_pulse = lost_q;
  assign lock_fail       = fail_q;
  assign retry_count     = retry_q;

endmodule

// File: tb/tb_ap1000_dcm_lock_supervisor.sv
// Directed bench for the DCM lock supervisor with short timing parameters.
module tb_ap1000_dcm_lock_supervisor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dcm_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       dcm_rst;
  logic       lock_ok;
  logic       lock_lost_pulse;
  logic       lock_fail;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;
  int n;
  logic bad;

  ap1000_dcm_lock_supervisor #(
    .RST_PULSE_CYCLES   (4'd4),
    .LOCK_TIMEOUT_CYCLES(16'd32),
    .STABLE_CYCLES      (4'd8),
    .MAX_RETRIES        (4'd2),
    .TIMER_W            (16)
  ) u_dut (
    .ref_clk         (clk),
    .async_fpga_rst_n(rst_n),
    .dcm_locked      (dcm_locked),
    .soft_rst_req    (soft_rst_req),
    .dcm_rst         (dcm_rst),
    .lock_ok         (lock_ok),
    .lock_lost_pulse (lock_lost_pulse),
    .lock_fail       (lock_fail),
    .retry_count     (retry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Edges until dcm_rst reaches the given level, bounded by limit.
  task automatic wait_dcm_rst(input logic level, input int limit, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end while (dcm_rst !== level && cnt < limit);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dcm_rst", int'(dcm_rst), 1);
    check("rst_lock_ok", int'(lock_ok), 0);
    check("rst_lost", int'(lock_lost_pulse), 0);
    check("rst_fail", int'(lock_fail), 0);
    check("rst_retry", int'(retry_count), 0);

    // Power-up pulse and first lock
    rst_n = 1'b1;
    wait_dcm_rst(1'b0, 30, n);
    check("t1_rst_len", n, 4);
    tick(10);
    dcm_locked = 1'b1;
    tick(10);
    check("t1_lock_ok_early", int'(lock_ok), 0);
    tick(1);
    check("t1_lock_ok", int'(lock_ok), 1);
    check("t1_retry", int'(retry_count), 0);

    // Loss of lock while LOCKED
    dcm_locked = 1'b0;
    tick(2);
    check("t4_still_ok", int'(lock_ok), 1);
    check("t4_no_lost_yet", int'(lock_lost_pulse), 0);
    tick(1);
    check("t4_lost", int'(lock_lost_pulse), 1);
    check("t4_lock_ok", int'(lock_ok), 0);
    check("t4_dcm_rst", int'(dcm_rst), 1);
    check("t4_retry", int'(retry_count), 0);
    tick(1);
    check("t4_lost_one_cycle", int'(lock_lost_pulse), 0);
    wait_dcm_rst(1'b0, 30, n);
    check("t4_rst_rest", n, 3);

    // One timeout while reacquiring
    wait_dcm_rst(1'b1, 60, n);
    check("t4_timeout_gap", n, 32);
    check("t4_retry_after_to", int'(retry_count), 1);
    wait_dcm_rst(1'b0, 30, n);
    check("t4_retry_rst_len", n, 4);

    // One-cycle glitch in STABLE_CHECK at stable_cnt=5
    dcm_locked = 1'b1;
    tick(6);
    dcm_locked = 1'b0;
    tick(1);
    dcm_locked = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (dcm_rst !== 1'b0 || lock_ok !== 1'b0) bad = 1'b1;
    end
    check("t3_no_early_lock_or_pulse", int'(bad), 0);
    tick(1);
    check("t3_lock_ok", int'(lock_ok), 1);
    check("t3_retry_kept", int'(retry_count), 1);

    // Soft request coinciding with lock loss in LOCKED
    dcm_locked = 1'b0;
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    check("t5b_lost", int'(lock_lost_pulse), 1);
    check("t5b_dcm_rst", int'(dcm_rst), 1);
    check("t5b_lock_ok", int'(lock_ok), 0);
    check("t5b_retry", int'(retry_count), 0);
    tick(1);
    check("t5b_lost_one_cycle", int'(lock_lost_pulse), 0);
    wait_dcm_rst(1'b0, 30, n);
    check("t5b_rst_rest", n, 3);

    // Lock never arrives: two retries then FAILED
    wait_dcm_rst(1'b1, 60, n);
    check("t2_gap1", n, 32);
    check("t2_retry1", int'(retry_count), 1);
    wait_dcm_rst(1'b0, 30, n);
    check("t2_pulse2", n, 4);
    wait_dcm_rst(1'b1, 60, n);
    check("t2_gap2", n, 32);
    check("t2_retry2", int'(retry_count), 2);
    wait_dcm_rst(1'b0, 30, n);
    check("t2_pulse3", n, 4);
    tick(31);
    check("t2_fail_early", int'(lock_fail), 0);
    tick(1);
    check("t2_fail", int'(lock_fail), 1);
    check("t2_dcm_rst_low", int'(dcm_rst), 0);
    check("t2_retry_sat", int'(retry_count), 2);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (dcm_rst !== 1'b0 || lock_fail !== 1'b1 || retry_count !== 4'd2) bad = 1'b1;
    end
    check("t2_failed_sticky", int'(bad), 0);

    // Soft request from FAILED, then again mid-pulse to restart it
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    check("t5a_fail_clr", int'(lock_fail), 0);
    check("t5a_dcm_rst", int'(dcm_rst), 1);
    check("t5a_retry", int'(retry_count), 0);
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    check("t5a_dcm_rst_mid", int'(dcm_rst), 1);
    wait_dcm_rst(1'b0, 30, n);
    check("t5a_restart_len", n, 4);

    // Async reset in WAIT_LOCK with a retry already charged
    wait_dcm_rst(1'b1, 60, n);
    check("t6_gap", n, 32);
    check("t6_retry_pre", int'(retry_count), 1);
    wait_dcm_rst(1'b0, 30, n);
    check("t6_pulse", n, 4);
    tick(5);
    #2 rst_n = 1'b0;
    #1;
    check("t6_dcm_rst", int'(dcm_rst), 1);
    check("t6_lock_ok", int'(lock_ok), 0);
    check("t6_retry", int'(retry_count), 0);
    check("t6_fail", int'(lock_fail), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_dcm_rst(1'b0, 30, n);
    check("t6_rst_len", n, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
